// File: rtl/hex_entry_pkg.sv
// Shared encodings for the hex entry controller: FSM states, cursor-to-nibble
// mapping and default debounce timing.
package hex_entry_pkg;

    typedef enum logic [1:0] {
        S_PT   = 2'd0,
        S_KEY  = 2'd1,
        S_SEND = 2'd2
    } state_e;

    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 1_000_000;
    localparam int unsigned CNT_W_DEFAULT           = 20;

    localparam int unsigned NIB_W    = 4;
    localparam int unsigned CUR0_LSB = 12;
    localparam int unsigned CUR1_LSB = 8;
    localparam int unsigned CUR2_LSB = 4;
    localparam int unsigned CUR3_LSB = 0;

    // Cursor 0 is the leftmost digit, so the slice moves right as cursor grows.
    function automatic logic [15:0] put_nibble(input logic [15:0] word,
                                               input logic [1:0]  cur,
                                               input logic [3:0]  nib);
        logic [15:0] res;
        res = word;
        case (cur)
            2'd0:    res[CUR0_LSB +: NIB_W] = nib;
            2'd1:    res[CUR1_LSB +: NIB_W] = nib;
            2'd2:    res[CUR2_LSB +: NIB_W] = nib;
            default: res[CUR3_LSB +: NIB_W] = nib;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/hex_entry_ctrl_btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stable-count debouncer and a
// one-cycle pulse on each debounced rising edge.
module btn_debounce
    import hex_entry_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned CNT_W           = CNT_W_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic pulse_o
);

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             level_q;
    logic             pulse_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
        end
    end

    // Any cycle back at the old level restarts the stability count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= 1'b0;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            pulse_q <= 1'b0;
            if (sync2_q != level_q) begin
                if (cnt_q == CntLast) begin
                    level_q <= sync2_q;
                    cnt_q   <= '0;
                    pulse_q <= sync2_q;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/hex_entry_ctrl.sv
// Nibble-at-a-time entry of a 16-bit plaintext and key with live display
// preview, handing the pair to the AES core over valid/ready.
module hex_entry_ctrl
    import hex_entry_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned CNT_W           = CNT_W_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  sw_i,
    input  logic        btn_next_i,
    input  logic        btn_enter_i,
    input  logic        btn_clear_i,
    output logic [3:0]  disp0_o,
    output logic [3:0]  disp1_o,
    output logic [3:0]  disp2_o,
    output logic [3:0]  disp3_o,
    output logic [1:0]  cursor_o,
    output logic [1:0]  state_o,
    output logic [15:0] pt_out_o,
    output logic [15:0] key_out_o,
    output logic        out_valid_o,
    input  logic        out_ready_i
);

    logic        next_p, enter_p, clear_p;
    logic [3:0]  sw_meta_q, sw_sync_q;
    state_e      state_q;
    logic [1:0]  cursor_q;
    logic [15:0] buf_q;
    logic [15:0] pt_q, key_q;
    logic        valid_q;
    logic [15:0] commit_word;
    logic [15:0] disp_word;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_next (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_i   (btn_next_i),
        .pulse_o (next_p)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_enter (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_i   (btn_enter_i),
        .pulse_o (enter_p)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_clear (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_i   (btn_clear_i),
        .pulse_o (clear_p)
    );

    // Switches are long settled by the time a debounced pulse arrives, so a
    // plain 2-FF synchronizer is enough for the committed value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_meta_q <= '0;
            sw_sync_q <= '0;
        end else begin
            sw_meta_q <= sw_i;
            sw_sync_q <= sw_meta_q;
        end
    end

    assign commit_word = put_nibble(buf_q, cursor_q, sw_sync_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_PT;
            cursor_q <= 2'd0;
            buf_q    <= '0;
            pt_q     <= '0;
            key_q    <= '0;
            valid_q  <= 1'b0;
        end else if (clear_p) begin
            state_q  <= S_PT;
            cursor_q <= 2'd0;
            buf_q    <= '0;
            valid_q  <= 1'b0;
        end else begin
            case (state_q)
                S_PT, S_KEY: begin
                    if (enter_p) begin
                        buf_q    <= '0;
                        cursor_q <= 2'd0;
                        if (state_q == S_PT) begin
                            pt_q    <= commit_word;
                            state_q <= S_KEY;
                        end else begin
                            key_q   <= commit_word;
                            valid_q <= 1'b1;
                            state_q <= S_SEND;
                        end
                    end else if (next_p) begin
                        buf_q    <= commit_word;
                        cursor_q <= cursor_q + 2'd1;
                    end
                end
                S_SEND: begin
                    if (out_ready_i) begin
                        valid_q <= 1'b0;
                        state_q <= S_PT;
                    end
                end
                default: begin
                    state_q <= S_PT;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    // The preview uses the raw switches so the digit reacts immediately.
    assign disp_word = (state_q == S_SEND) ? key_q : put_nibble(buf_q, cursor_q, sw_i);

    assign disp0_o     = disp_word[3:0];
    assign disp1_o     = disp_word[7:4];
    assign disp2_o     = disp_word[11:8];
    assign disp3_o     = disp_word[15:12];
    assign cursor_o    = cursor_q;
    assign state_o     = state_q;
    assign pt_out_o    = pt_q;
    assign key_out_o   = key_q;
    assign out_valid_o = valid_q;

endmodule

// File: tb/tb_hex_entry_ctrl.sv
// Self-checking bench for hex_entry_ctrl with a short debounce window and a
// transfer scoreboard on the valid/ready port.
module tb_hex_entry_ctrl;

    localparam int unsigned N    = 16;
    localparam int unsigned HOLD = N + 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  sw_i;
    logic        btn_next_i, btn_enter_i, btn_clear_i;
    logic [3:0]  disp0_o, disp1_o, disp2_o, disp3_o;
    logic [1:0]  cursor_o, state_o;
    logic [15:0] pt_out_o, key_out_o;
    logic        out_valid_o;
    logic        out_ready_i;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_q[$];

    hex_entry_ctrl #(.DEBOUNCE_CYCLES(N), .CNT_W(5)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sw_i        (sw_i),
        .btn_next_i  (btn_next_i),
        .btn_enter_i (btn_enter_i),
        .btn_clear_i (btn_clear_i),
        .disp0_o     (disp0_o),
        .disp1_o     (disp1_o),
        .disp2_o     (disp2_o),
        .disp3_o     (disp3_o),
        .cursor_o    (cursor_o),
        .state_o     (state_o),
        .pt_out_o    (pt_out_o),
        .key_out_o   (key_out_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i)
    );

    always #5 clk = ~clk;

    // Transfer scoreboard: each accepted pair must match the oldest expected one.
    always begin
        logic [31:0] exp;
        @(negedge clk);
        #2;
        if (rst_n && out_valid_o && out_ready_i) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL xfer_unexpected: got pt=%h key=%h, required no transfer",
                         pt_out_o, key_out_o);
            end else begin
                exp = exp_q.pop_front();
                if ({pt_out_o, key_out_o} !== exp)
                    $display("FAIL xfer_data: got %h, required %h", {pt_out_o, key_out_o}, exp);
                else
                    n_pass++;
            end
        end
    end

    task automatic press(input logic nxt, input logic ent, input logic clr);
        btn_next_i  = nxt;
        btn_enter_i = ent;
        btn_clear_i = clr;
        repeat (HOLD) @(negedge clk);
        btn_next_i  = 1'b0;
        btn_enter_i = 1'b0;
        btn_clear_i = 1'b0;
        repeat (HOLD) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        sw_i  = 4'h5;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({state_o, cursor_o, out_valid_o} !== 5'b0)
            $display("FAIL reset_ctrl: got %b, required 00000", {state_o, cursor_o, out_valid_o});
        else n_pass++;
        n_checks++;
        if ({pt_out_o, key_out_o} !== 32'h0)
            $display("FAIL reset_data: got %h, required 0", {pt_out_o, key_out_o});
        else n_pass++;
        n_checks++;
        if ({disp3_o, disp2_o, disp1_o, disp0_o} !== 16'h5000)
            $display("FAIL reset_disp: got %h, required 5000",
                     {disp3_o, disp2_o, disp1_o, disp0_o});
        else n_pass++;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_bounce();
        sw_i = 4'h9;
        for (int i = 0; i < 12; i++) begin
            btn_next_i = (i % 2 == 0);
            repeat (5) @(negedge clk);
        end
        n_checks++;
        if (cursor_o !== 2'd0) $display("FAIL bounce_quiet: got cursor %0d, required 0", cursor_o);
        else n_pass++;
        btn_next_i = 1'b1;
        repeat (HOLD) @(negedge clk);
        btn_next_i = 1'b0;
        repeat (HOLD) @(negedge clk);
        n_checks++;
        if ({cursor_o, disp3_o} !== {2'd1, 4'h9})
            $display("FAIL bounce_one_next: got cursor %0d disp3 %h, required 1 9",
                     cursor_o, disp3_o);
        else n_pass++;
        press(1'b0, 1'b0, 1'b1);
        n_checks++;
        if ({state_o, cursor_o, disp3_o, disp2_o} !== {2'd0, 2'd0, 4'h9, 4'h0})
            $display("FAIL bounce_clear: got %h, required 0090",
                     {state_o, cursor_o, disp3_o, disp2_o});
        else n_pass++;
    endtask

    task automatic test_entry();
        int lat;
        sw_i = 4'h1; press(1'b1, 1'b0, 1'b0);
        sw_i = 4'h2; press(1'b1, 1'b0, 1'b0);
        sw_i = 4'h3; press(1'b1, 1'b0, 1'b0);
        sw_i = 4'h4; press(1'b0, 1'b1, 1'b0);
        n_checks++;
        if ({state_o, cursor_o, out_valid_o, pt_out_o} !== {2'd1, 2'd0, 1'b0, 16'h1234})
            $display("FAIL entry_pt: got st %0d cur %0d v %b pt %h, required 1 0 0 1234",
                     state_o, cursor_o, out_valid_o, pt_out_o);
        else n_pass++;
        sw_i = 4'hA; press(1'b1, 1'b0, 1'b0);
        sw_i = 4'hB; press(1'b1, 1'b0, 1'b0);
        sw_i = 4'hC; press(1'b1, 1'b0, 1'b0);
        sw_i = 4'hD;
        exp_q.push_back({16'h1234, 16'hABCD});
        // 2 sync + N stable + 1 pulse stage, valid registered on the pulse edge.
        btn_enter_i = 1'b1;
        lat = 0;
        while (!out_valid_o && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        n_checks++;
        if (lat != N + 3) $display("FAIL entry_latency: got %0d cycles, required %0d", lat, N + 3);
        else n_pass++;
        repeat (HOLD) @(negedge clk);
        btn_enter_i = 1'b0;
        repeat (HOLD) @(negedge clk);
        n_checks++;
        if ({state_o, out_valid_o, key_out_o, pt_out_o} !== {2'd2, 1'b1, 16'hABCD, 16'h1234})
            $display("FAIL entry_key: got st %0d v %b key %h pt %h, required 2 1 abcd 1234",
                     state_o, out_valid_o, key_out_o, pt_out_o);
        else n_pass++;
        n_checks++;
        if ({disp3_o, disp2_o, disp1_o, disp0_o} !== 16'hABCD)
            $display("FAIL entry_send_disp: got %h, required abcd",
                     {disp3_o, disp2_o, disp1_o, disp0_o});
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int bad;
        bad = 0;
        out_ready_i = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (out_valid_o !== 1'b1 || pt_out_o !== 16'h1234 || key_out_o !== 16'hABCD) bad++;
        end
        n_checks++;
        if (bad != 0) $display("FAIL bp_hold: got %0d bad cycles, required 0", bad);
        else n_pass++;
        sw_i = 4'hF;
        press(1'b0, 1'b1, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        n_checks++;
        if ({state_o, out_valid_o, key_out_o} !== {2'd2, 1'b1, 16'hABCD})
            $display("FAIL bp_ignore_btn: got st %0d v %b key %h, required 2 1 abcd",
                     state_o, out_valid_o, key_out_o);
        else n_pass++;
        out_ready_i = 1'b1;
        @(negedge clk);
        out_ready_i = 1'b0;
        n_checks++;
        if ({state_o, out_valid_o} !== {2'd0, 1'b0})
            $display("FAIL bp_accept: got st %0d v %b, required 0 0", state_o, out_valid_o);
        else n_pass++;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_wrap_preview();
        sw_i = 4'h7;
        for (int i = 0; i < 5; i++) press(1'b1, 1'b0, 1'b0);
        n_checks++;
        if ({cursor_o, disp3_o} !== {2'd1, 4'h7})
            $display("FAIL wrap_cursor: got cur %0d disp3 %h, required 1 7", cursor_o, disp3_o);
        else n_pass++;
        sw_i = 4'h3;
        #1;
        n_checks++;
        if ({disp3_o, disp2_o, disp1_o, disp0_o} !== 16'h7377)
            $display("FAIL wrap_preview_a: got %h, required 7377",
                     {disp3_o, disp2_o, disp1_o, disp0_o});
        else n_pass++;
        sw_i = 4'hC;
        #1;
        n_checks++;
        if ({disp3_o, disp2_o} !== 8'h7C)
            $display("FAIL wrap_preview_b: got %h, required 7c", {disp3_o, disp2_o});
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_priority();
        press(1'b0, 1'b0, 1'b1);
        sw_i = 4'h5; press(1'b0, 1'b1, 1'b0);
        n_checks++;
        if ({state_o, pt_out_o} !== {2'd1, 16'h5000})
            $display("FAIL prio_pt: got st %0d pt %h, required 1 5000", state_o, pt_out_o);
        else n_pass++;
        sw_i = 4'h6; press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b1);
        n_checks++;
        if ({state_o, cursor_o, key_out_o, pt_out_o} !== {2'd0, 2'd0, 16'hABCD, 16'h5000})
            $display("FAIL prio_clear_enter: got st %0d cur %0d key %h pt %h, required 0 0 abcd 5000",
                     state_o, cursor_o, key_out_o, pt_out_o);
        else n_pass++;
        n_checks++;
        if ({disp3_o, disp2_o, disp1_o, disp0_o} !== 16'h6000)
            $display("FAIL prio_buf_cleared: got %h, required 6000",
                     {disp3_o, disp2_o, disp1_o, disp0_o});
        else n_pass++;
        sw_i = 4'h8; press(1'b1, 1'b1, 1'b0);
        n_checks++;
        if ({state_o, cursor_o, pt_out_o} !== {2'd1, 2'd0, 16'h8000})
            $display("FAIL prio_enter_next: got st %0d cur %0d pt %h, required 1 0 8000",
                     state_o, cursor_o, pt_out_o);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        sw_i = 4'h1; press(1'b1, 1'b0, 1'b0);
        sw_i = 4'h2; press(1'b1, 1'b0, 1'b0);
        sw_i = 4'h0;
        #1;
        n_checks++;
        if ({state_o, cursor_o, disp3_o, disp2_o} !== {2'd1, 2'd2, 8'h12})
            $display("FAIL mid_setup: got %h, required 612", {state_o, cursor_o, disp3_o, disp2_o});
        else n_pass++;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        sw_i  = 4'h2;
        #1;
        n_checks++;
        if ({state_o, cursor_o, out_valid_o, pt_out_o, key_out_o} !== 37'h0)
            $display("FAIL mid_reset: got st %0d cur %0d v %b pt %h key %h, required all 0",
                     state_o, cursor_o, out_valid_o, pt_out_o, key_out_o);
        else n_pass++;
        n_checks++;
        if ({disp3_o, disp2_o, disp1_o, disp0_o} !== 16'h2000)
            $display("FAIL mid_reset_disp: got %h, required 2000",
                     {disp3_o, disp2_o, disp1_o, disp0_o});
        else n_pass++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        out_ready_i = 1'b1;
        sw_i = 4'hF; press(1'b1, 1'b0, 1'b0);
        sw_i = 4'h0; press(1'b1, 1'b0, 1'b0);
        sw_i = 4'h0; press(1'b1, 1'b0, 1'b0);
        sw_i = 4'hD; press(1'b0, 1'b1, 1'b0);
        n_checks++;
        if ({state_o, pt_out_o} !== {2'd1, 16'hF00D})
            $display("FAIL b2b_pt: got st %0d pt %h, required 1 f00d", state_o, pt_out_o);
        else n_pass++;
        exp_q.push_back({16'hF00D, 16'hC000});
        sw_i = 4'hC; press(1'b0, 1'b1, 1'b0);
        n_checks++;
        if ({state_o, out_valid_o, key_out_o} !== {2'd0, 1'b0, 16'hC000})
            $display("FAIL b2b_done: got st %0d v %b key %h, required 0 0 c000",
                     state_o, out_valid_o, key_out_o);
        else n_pass++;
        out_ready_i = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        btn_next_i  = 1'b0;
        btn_enter_i = 1'b0;
        btn_clear_i = 1'b0;
        out_ready_i = 1'b0;
        test_reset();
        test_bounce();
        test_entry();
        test_backpressure();
        test_wrap_preview();
        test_priority();
        test_reset_mid();
        test_back_to_back();
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL xfer_missing: got %0d pending, required 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
